digdug_vram_server: RTL

Memory-side responder for the DigDug video scan ports. Holds the 1 KiB foreground VRAM and the sprite attribute RAM (working plus display copy), and serves the video block's FGSCAD/SPATAD scan reads with fixed latency. Arbitrates CPU reads and writes against those scans. Copies working sprite attributes into the display copy once per frame at vertical blank, so the sprite scanner never sees a half-updated table.

---
 rtl/digdug_vram_server.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/digdug_vram_server.sv
// DigDug VRAM server: FG VRAM and sprite attribute RAM responder for the video scan ports,
// CPU access arbitration, and a once-per-frame working-to-display sprite table copy.
//
// copy engine states
//   state   | meaning
//   ST_IDLE | waiting for a VBLK rising edge
//   ST_COPY | copying WORK[cnt] -> DISP[cnt], stalled while a sprite scan owns DISP
//   ST_DONE | final cycle of COPY_BUSY, returns to idle
module digdug_vram_server #(
    parameter int SPN = 128,
    parameter int FGW = 10
) (
    input  logic                   CLK48M,
    input  logic                   RESET_N,
    input  logic                   FGSCCL,
    input  logic [FGW-1:0]         FGSCAD,
    output logic [7:0]             FGSCDT,
    input  logic                   SPATCL,
    input  logic [$clog2(SPN)-1:0] SPATAD,
    output logic [23:0]            SPATDT,
    input  logic                   VBLK,
    input  logic [10:0]            CPU_AD,
    input  logic                   CPU_WR,
    input  logic                   CPU_RD,
    input  logic [7:0]             CPU_DI,
    output logic [7:0]             CPU_DO,
    output logic                   CPU_ACK,
    output logic                   COPY_BUSY
);
    localparam int SPW = $clog2(SPN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_DONE = 2'd2
    } copy_state_t;

    logic [7:0]  fg_ram [2**FGW];
    logic [7:0]  work0  [SPN];
    logic [7:0]  work1  [SPN];
    logic [7:0]  work2  [SPN];
    logic [23:0] disp   [SPN];

    logic           fgsccl_q, spatcl_q, vblk_q;
    logic           fg_edge, sp_edge, vblk_edge;
    logic           fg_rq, sp_rq;
    logic [FGW-1:0] fg_ad_q;
    logic [SPW-1:0] sp_ad_q;

    logic           req_v, req_wr, need_drop;
    logic [10:0]    req_ad;
    logic [7:0]     req_di;
    logic           req_fg, req_sp;
    logic [1:0]     req_bank;
    logic [SPW-1:0] req_idx;
    logic           accept, serve;
    logic [7:0]     cpu_rdata;

    logic           fg_we, disp_we;
    logic [2:0]     work_we;

    copy_state_t    state_q, state_d;
    logic [SPW-1:0] cnt_q, cnt_d;

    assign fg_edge   = FGSCCL & ~fgsccl_q;
    assign sp_edge   = SPATCL & ~spatcl_q;
    assign vblk_edge = VBLK & ~vblk_q;

    // 0x400/0x480/0x500 select banks 0/1/2; 0x580 and above is unmapped
    assign req_fg   = ~req_ad[10];
    assign req_sp   = req_ad[10] & ~req_ad[9] & ~(req_ad[8] & req_ad[7]);
    assign req_bank = req_ad[8:7];
    assign req_idx  = req_ad[SPW-1:0];

    // A held request is accepted only once the previous ACK has been followed by an idle cycle
    assign accept = (CPU_WR | CPU_RD) & ~req_v & ~need_drop;
    assign serve  = req_v & ~(req_fg & fg_rq);

    always_comb begin
        cpu_rdata = 8'hFF;
        if (req_fg) begin
            cpu_rdata = fg_ram[req_ad[FGW-1:0]];
        end else if (req_sp) begin
            case (req_bank)
                2'd0:    cpu_rdata = work0[req_idx];
                2'd1:    cpu_rdata = work1[req_idx];
                default: cpu_rdata = work2[req_idx];
            endcase
        end
    end

    always_comb begin
        fg_we   = 1'b0;
        work_we = 3'b000;
        disp_we = 1'b0;
        if (RESET_N && serve && req_wr) begin
            if (req_fg) begin
                fg_we = 1'b1;
            end else if (req_sp) begin
                case (req_bank)
                    2'd0:    work_we = 3'b001;
                    2'd1:    work_we = 3'b010;
                    default: work_we = 3'b100;
                endcase
            end
        end
        if (RESET_N && (state_q == ST_COPY) && !sp_rq) begin
            disp_we = 1'b1;
        end
    end

    // RAM arrays carry no reset; contents survive RESET_N
    always_ff @(posedge CLK48M) begin
        if (fg_we) begin
            fg_ram[req_ad[FGW-1:0]] <= req_di;
        end
        if (work_we[0]) begin
            work0[req_idx] <= req_di;
        end
        if (work_we[1]) begin
            work1[req_idx] <= req_di;
        end
        if (work_we[2]) begin
            work2[req_idx] <= req_di;
        end
        if (disp_we) begin
            disp[cnt_q] <= {work2[cnt_q], work1[cnt_q], work0[cnt_q]};
        end
    end

    always_ff @(posedge CLK48M) begin
        if (!RESET_N) begin
            fgsccl_q  <= 1'b0;
            spatcl_q  <= 1'b0;
            vblk_q    <= 1'b0;
            fg_rq     <= 1'b0;
            sp_rq     <= 1'b0;
            fg_ad_q   <= '0;
            sp_ad_q   <= '0;
            req_v     <= 1'b0;
            req_wr    <= 1'b0;
            req_ad    <= '0;
            req_di    <= '0;
            need_drop <= 1'b0;
        end else begin
            fgsccl_q <= FGSCCL;
            spatcl_q <= SPATCL;
            vblk_q   <= VBLK;
            fg_rq    <= fg_edge;
            sp_rq    <= sp_edge;
            if (fg_edge) begin
                fg_ad_q <= FGSCAD;
            end
            if (sp_edge) begin
                sp_ad_q <= SPATAD;
            end
            if (accept) begin
                req_v  <= 1'b1;
                req_wr <= CPU_WR;
                req_ad <= CPU_AD;
                req_di <= CPU_DI;
            end else if (serve) begin
                req_v <= 1'b0;
            end
            if (serve) begin
                need_drop <= 1'b1;
            end else if (!(CPU_WR | CPU_RD)) begin
                need_drop <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK48M) begin
        if (!RESET_N) begin
            FGSCDT  <= '0;
            SPATDT  <= '0;
            CPU_DO  <= '0;
            CPU_ACK <= 1'b0;
        end else begin
            if (fg_rq) begin
                FGSCDT <= fg_ram[fg_ad_q];
            end
            if (sp_rq) begin
                SPATDT <= disp[sp_ad_q];
            end
            CPU_ACK <= serve;
            if (serve && !req_wr) begin
                CPU_DO <= cpu_rdata;
            end
        end
    end

    always_ff @(posedge CLK48M) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (vblk_edge) begin
                    state_d = ST_COPY;
                    cnt_d   = '0;
                end
            end
            ST_COPY: begin
                if (!sp_rq) begin
                    if (cnt_q == SPW'(SPN - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign COPY_BUSY = (state_q != ST_IDLE);

endmodule
